lsu_port: RTL and testbench
===========================

Name: lsu_port

Overview:
- Load/store initiator between the pipeline memory stage and the block-RAM data memory.
- Accepts one load or store request at a time from the pipeline and drives the memory port: write enable, 2-bit size code, byte address and write data.
- Waits out the memory's one-cycle registered read.
- Extracts the addressed byte/halfword and sign- or zero-extends it.
- Flags misaligned, illegal-size and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 4096: number of 32-bit words in the data memory; word index addr[31:2] must be below this.
- ADDR_W, 32: request and memory address width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  pipeline has a request
- req_ready  output  1  LSU idle, request accepted when req_valid&req_ready
- req_write  input  1  1=store, 0=load
- req_funct3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  one-cycle completion pulse
- rsp_err  output  1  qualifies rsp_valid: access rejected
- rsp_rdata  output  32  extended load data, 0 for stores/errors
- mem_we  output  1  memory write enable
- mem_size  output  2  00 word, 01 byte, 10 half
- mem_addr  output  ADDR_W  byte address to memory
- mem_wdata  output  32  write data to memory
- mem_rdata  input  32  memory read word, valid the cycle after the address is sampled with mem_we=0

Behaviour:
- States: IDLE, ISSUE, CAPTURE, RESP.
- req_ready = (state==IDLE). All other outputs are registered.
- Reset (any state): state IDLE; rsp_valid, rsp_err, mem_we = 0; rsp_rdata, mem_addr, mem_wdata = 0; mem_size = 00. Any in-flight request is dropped with no response.
- Accept in cycle 0, checked in this order:
  - Illegal funct3: load 011/110/111, store bit2=1 -> err.
  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0 -> err.
  - Out of range: addr[ADDR_W-1:2] >= MEM_WORDS -> err.
- Error path: cycle 1 rsp_valid=1, rsp_err=1, rsp_rdata=0; state stays IDLE. mem_we is never asserted and mem_addr is unchanged.
- Good request: go to ISSUE. mem_addr=req_addr, mem_size from funct3[1:0] (00->01, 01->10, 10->00). mem_wdata=req_wdata unshifted, because memory takes sub-word data from the low lanes. mem_we=req_write.
- ISSUE (cycle 1): memory samples at the end of the cycle.
  - Store: next state RESP, mem_we drops to 0.
  - Load: next state CAPTURE.
- CAPTURE (cycle 2): mem_rdata is valid. Select the lane by addr[1:0] (byte) or addr[1] (half). funct3[2]=0 sign-extends, 1 zero-extends. Register the result into rsp_rdata, then go to RESP.
- RESP: rsp_valid=1, rsp_err=0 for one cycle, then IDLE.
- Response timing: store rsp_valid in cycle 2, load in cycle 3. req_ready=1 in the cycle rsp_valid is high? No: req_ready returns in the cycle after RESP.
- mem_addr holds from ISSUE until the next good accept, so the read word is stable. mem_we is high for exactly one cycle per store.
- req_valid outside IDLE is ignored. Its inputs are not sampled.
- Simultaneous reset and req_valid: reset wins, nothing is accepted.

Decomposition:
- lsu_pkg: funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101), mem_size codes (SZ_WORD=00, SZ_BYTE=01, SZ_HALF=10), state enum.
- One combinational sub-module load_extract (word, addr[1:0], funct3 -> 32-bit result), reused by the bench's reference model.

Test Plan:
- Memory word 0x100=0x876543A1; LB 0x100 -> rsp_rdata 0xFFFFFFA1 in cycle 3; LBU 0x100 -> 0x000000A1; LB 0x101 -> 0x00000043; LB 0x103 -> 0xFFFFFF87.
- Same word; LH 0x102 -> 0xFFFF8765; LHU 0x102 -> 0x00008765; LW 0x100 -> 0x876543A1.
- SB 0x105 wdata 0x123456CC -> cycle 1 mem_we=1, mem_size=01, mem_addr=0x105, mem_wdata=0x123456CC; rsp_valid cycle 2; then LW 0x104 shows bits[15:8]=0xCC.
- LW 0x102, SH 0x101, funct3=011 load, LW 0x4000 (word 4096) -> each gives rsp_valid=1, rsp_err=1 in cycle 1; mem_we stays 0; mem_addr unchanged.
- Reset asserted in CAPTURE of LW 0x100 -> no rsp_valid; next cycle req_ready=1 and all outputs at reset values.
- req_valid held high with a LW stream -> accepts spaced exactly 4 cycles apart; one rsp_valid per accept, in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store port: funct3 values, memory size codes
// and the FSM state type.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} lsu_state_t;

    function automatic logic [1:0] size_code(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   size_code = SZ_BYTE;
            2'b01:   size_code = SZ_HALF;
            default: size_code = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it according to funct3.
module load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic        sext;

    always_comb begin
        sel_b = word[{addr_lo, 3'b000} +: 8];
        sel_h = addr_lo[1] ? word[31:16] : word[15:0];
        sext  = ~funct3[2];
        case (funct3[1:0])
            2'b00:   result = {{24{sel_b[7] & sext}}, sel_b};
            2'b01:   result = {{16{sel_h[15] & sext}}, sel_h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/lsu_port.sv
// Load/store initiator between the memory stage and a block-RAM data memory
// with a one-cycle registered read.
//   state   | meaning
//   IDLE    | ready for a request; rejected requests respond from here
//   ISSUE   | address/write on the memory port, memory samples this cycle
//   CAPTURE | read word valid, extracted load data registered
//   RESP    | rsp_valid high for one cycle
module lsu_port
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(MEM_WORDS);

    lsu_state_t        state, state_d;
    logic              write_q, write_d;
    logic [2:0]        f3_q, f3_d;
    logic              rsp_valid_d, rsp_err_d, mem_we_d;
    logic [31:0]       rsp_rdata_d, mem_wdata_d;
    logic [1:0]        mem_size_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              illegal, misaligned, out_of_range;
    logic [31:0]       load_data;

    load_extract u_extract (
        .word    (mem_rdata),
        .addr_lo (mem_addr[1:0]),
        .funct3  (f3_q),
        .result  (load_data)
    );

    assign req_ready = (state == IDLE);

    // Stores with funct3[1:0]=11 have no size code, so they are rejected too.
    always_comb begin
        illegal      = req_write ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                                 : ((req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11));
        misaligned   = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                     | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr[ADDR_W-1:2] >= WORD_LIMIT);
    end

    always_comb begin
        state_d     = state;
        write_d     = write_q;
        f3_d        = f3_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata;
        mem_we_d    = 1'b0;
        mem_size_d  = mem_size;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    rsp_rdata_d = 32'd0;
                    if (illegal || misaligned || out_of_range) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        write_d     = req_write;
                        f3_d        = req_funct3;
                        mem_we_d    = req_write;
                        mem_size_d  = size_code(req_funct3[1:0]);
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ISSUE: begin
                if (write_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_data;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            f3_q      <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            mem_we    <= 1'b0;
            mem_size  <= SZ_WORD;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            state     <= state_d;
            write_q   <= write_d;
            f3_q      <= f3_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            mem_we    <= mem_we_d;
            mem_size  <= mem_size_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_port.sv
// Directed bench for lsu_port against a small registered-read memory model.
module tb_lsu_port;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    lsu_port #(.MEM_WORDS(4096), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .mem_we     (mem_we),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Reference extraction for the second data word.
    logic [1:0]  ref_lo;
    logic [2:0]  ref_f3;
    logic [31:0] ref_res;
    load_extract u_ref (
        .word    (32'h80FF7F01),
        .addr_lo (ref_lo),
        .funct3  (ref_f3),
        .result  (ref_res)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    logic        init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            mem[12'h040] <= 32'h876543A1;
            mem[12'h041] <= 32'h00000000;
            mem[12'h080] <= 32'h80FF7F01;
            init_done    <= 1'b1;
        end else if (mem_we) begin
            case (mem_size)
                SZ_BYTE: mem[mem_addr[13:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
                SZ_HALF: mem[mem_addr[13:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                default: mem[mem_addr[13:2]] <= mem_wdata;
            endcase
        end
        mem_rdata <= mem[mem_addr[13:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp);
        chk({tag, " ready0"}, {31'd0, req_ready}, 32'd1);
        drive(1'b0, f3, a, 32'hDEADBEEF);
        step();
        req_valid = 1'b0;
        chk({tag, " c1 addr"}, mem_addr, a);
        chk({tag, " c1 we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, " c1 ready"}, {31'd0, req_ready}, 32'd0);
        step();
        chk({tag, " c2 rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        step();
        chk({tag, " c3 rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, " c3 rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, " c3 rdata"}, rsp_rdata, exp);
        step();
        chk({tag, " c4 rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] sz);
        drive(1'b1, f3, a, wd);
        step();
        req_valid = 1'b0;
        chk({tag, " c1 we"}, {31'd0, mem_we}, 32'd1);
        chk({tag, " c1 size"}, {30'd0, mem_size}, {30'd0, sz});
        chk({tag, " c1 addr"}, mem_addr, a);
        chk({tag, " c1 wdata"}, mem_wdata, wd);
        step();
        chk({tag, " c2 rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, " c2 rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, " c2 rdata"}, rsp_rdata, 32'd0);
        chk({tag, " c2 we"}, {31'd0, mem_we}, 32'd0);
        step();
        chk({tag, " c3 ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_err(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] held_addr);
        drive(wr, f3, a, 32'hFFFFFFFF);
        step();
        req_valid = 1'b0;
        chk({tag, " c1 rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, " c1 rsp_err"}, {31'd0, rsp_err}, 32'd1);
        chk({tag, " c1 rdata"}, rsp_rdata, 32'd0);
        chk({tag, " c1 we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, " c1 addr"}, mem_addr, held_addr);
        chk({tag, " c1 ready"}, {31'd0, req_ready}, 32'd1);
        step();
        chk({tag, " c2 rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, " c2 we"}, {31'd0, mem_we}, 32'd0);
    endtask

    logic [31:0] s_addr [3];
    logic [31:0] s_val  [3];
    logic [31:0] exp_q  [$];
    int          last_acc, n_acc, n_rsp;

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        ref_lo     = 2'd0;
        ref_f3     = 3'd0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst ready", {31'd0, req_ready}, 32'd1);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst we", {31'd0, mem_we}, 32'd0);
        chk("rst addr", mem_addr, 32'd0);
        chk("rst size", {30'd0, mem_size}, 32'd0);

        do_load("LB 100",  F3_B,  32'h100, 32'hFFFFFFA1);
        do_load("LBU 100", F3_BU, 32'h100, 32'h000000A1);
        do_load("LB 101",  F3_B,  32'h101, 32'h00000043);
        do_load("LB 103",  F3_B,  32'h103, 32'hFFFFFF87);
        do_load("LH 102",  F3_H,  32'h102, 32'hFFFF8765);
        do_load("LHU 102", F3_HU, 32'h102, 32'h00008765);
        do_load("LW 100",  F3_W,  32'h100, 32'h876543A1);

        do_store("SB 105", F3_B, 32'h105, 32'h123456CC, SZ_BYTE);
        do_load("LW 104", F3_W, 32'h104, 32'h0000CC00);

        do_err("LW 102",   1'b0, F3_W,   32'h102,  32'h104);
        do_err("SH 101",   1'b1, F3_H,   32'h101,  32'h104);
        do_err("L f3 011", 1'b0, 3'b011, 32'h100,  32'h104);
        do_err("LW 4000",  1'b0, F3_W,   32'h4000, 32'h104);
        do_err("SB f3 100", 1'b1, 3'b100, 32'h100, 32'h104);

        ref_lo = 2'd2; ref_f3 = F3_H;
        #1 do_load("LH 202", F3_H, 32'h202, ref_res);
        chk("LH 202 hand", rsp_rdata, 32'hFFFF80FF);
        ref_lo = 2'd3; ref_f3 = F3_BU;
        #1 do_load("LBU 203", F3_BU, 32'h203, ref_res);
        ref_lo = 2'd1; ref_f3 = F3_B;
        #1 do_load("LB 201", F3_B, 32'h201, ref_res);
        ref_lo = 2'd0; ref_f3 = F3_HU;
        #1 do_load("LHU 200", F3_HU, 32'h200, ref_res);

        // Reset while the load sits in CAPTURE.
        drive(1'b0, F3_W, 32'h100, 32'd0);
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("rstcap rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstcap ready", {31'd0, req_ready}, 32'd1);
        chk("rstcap addr", mem_addr, 32'd0);
        chk("rstcap rdata", rsp_rdata, 32'd0);
        chk("rstcap wdata", mem_wdata, 32'd0);
        chk("rstcap size", {30'd0, mem_size}, 32'd0);
        chk("rstcap err", {31'd0, rsp_err}, 32'd0);
        drive(1'b0, F3_W, 32'h100, 32'd0);
        step();
        chk("rst+req ready", {31'd0, req_ready}, 32'd1);
        chk("rst+req addr", mem_addr, 32'd0);
        chk("rst+req rsp_valid", {31'd0, rsp_valid}, 32'd0);
        req_valid = 1'b0;
        reset = 1'b0;
        step();
        step();
        chk("post-rst rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Back-to-back load stream with req_valid held high.
        s_addr[0] = 32'h100; s_val[0] = 32'h876543A1;
        s_addr[1] = 32'h104; s_val[1] = 32'h0000CC00;
        s_addr[2] = 32'h200; s_val[2] = 32'h80FF7F01;
        last_acc = -1; n_acc = 0; n_rsp = 0;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = s_addr[0];
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) begin
                if (exp_q.size() > 0) chk("stream rdata", rsp_rdata, exp_q.pop_front());
                else chk("stream extra rsp", 32'd1, 32'd0);
                n_rsp++;
            end
            if (req_ready) begin
                if (last_acc >= 0) chk("stream gap", 32'(c - last_acc), 32'd4);
                last_acc = c;
                req_addr = s_addr[n_acc % 3];
                exp_q.push_back(s_val[n_acc % 3]);
                n_acc++;
            end
            step();
        end
        req_valid = 1'b0;
        chk("stream accepts", 32'(n_acc), 32'd5);
        chk("stream responses", 32'(n_rsp), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
